// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state and command types for the APB requester.
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_mst_state_t;
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apb_cmd_t;
endpackage

// File: rtl/apb_cmd_fifo.sv
// apb_cmd_fifo: synchronous command FIFO; push of full and pop of empty are ignored.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     pclk,
    input  logic     rst,
    input  logic     push,
    input  apb_cmd_t din,
    input  logic     pop,
    output apb_cmd_t dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);
    apb_cmd_t   r_mem [DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic        w_push, w_pop;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full   = (r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}};
    assign empty  = r_wptr == r_rptr;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rptr[AW-1:0]];
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= r_wptr + {{AW{1'b0}}, w_push};
            r_rptr <= r_rptr + {{AW{1'b0}}, w_pop};
        end
    end
    always_ff @(posedge pclk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/apb_master.sv
// apb_master: buffers commands and runs them in order as APB SETUP/ACCESS transfers,
// returning a one-cycle response and aborting with an error if pready never arrives.
module apb_master
    import apb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    apb_mst_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_psel, r_penable, r_pwrite, r_rsp_valid, r_rsp_err;
    logic [31:0]    r_paddr, r_pwdata, r_rsp_rdata;
    logic           w_psel_nxt, w_penable_nxt, w_pwrite_nxt, w_rsp_valid_nxt, w_rsp_err_nxt;
    logic [31:0]    w_paddr_nxt, w_pwdata_nxt, w_rsp_rdata_nxt;
    logic           w_pop, w_full, w_empty, w_done;
    apb_cmd_t       w_head;
    apb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .pclk  (pclk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   ('{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );
    assign cmd_ready = !w_full;
    assign w_done    = pready || r_cnt == CW'(TIMEOUT_CYCLES - 1);
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_pop           = 1'b0;
        case (r_state)
            IDLE: if (!w_empty) begin
                w_pop        = 1'b1;
                w_psel_nxt   = 1'b1;
                w_pwrite_nxt = w_head.write;
                w_paddr_nxt  = w_head.addr;
                w_pwdata_nxt = w_head.wdata;
                w_state_nxt  = SETUP;
            end
            SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = ACCESS;
            end
            ACCESS: if (w_done) begin
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = !pready;
                w_rsp_rdata_nxt = (pready && !r_pwrite) ? prdata : 32'h0;
                w_state_nxt     = IDLE;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: random commands against a behavioural APB slave and an in-order
// response model; word 1 (address 0x4) is a slave hole that never asserts pready.
module tb_apb_master;
    logic        pclk, rst, cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        psel, penable, pwrite, pready, rsp_valid, rsp_err;
    logic [31:0] paddr, pwdata, prdata, rsp_rdata;
    int          n_chk, n_fail;
    logic [31:0] smem [16];
    logic [31:0] mmem [16];
    logic [32:0] exp_q [$];
    logic        mon_on, in_setup, prev_acc, hole, lat_w;
    logic [31:0] lat_addr, lat_d;
    int          acc_cnt, wait_st;
    apb_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask
    // Slave model and bus protocol monitor; drives pready/prdata on the falling edge.
    always @(negedge pclk) begin
        if (!mon_on) begin
            acc_cnt = 0; in_setup = 0; prev_acc = 0; pready = 0; prdata = '0;
        end else begin
            if (rsp_valid) begin
                chk("rsp_after_access", {31'b0, prev_acc}, 32'd1);
                if (exp_q.size() == 0) chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
                else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e[31:0]);
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
                end
            end
            if (!(psel && penable) && acc_cnt != 0) begin
                chk("access_len", 32'(acc_cnt), hole ? 32'd16 : 32'(wait_st + 1));
                acc_cnt = 0;
            end
            if (psel && !penable) begin
                if (in_setup) chk("setup_one_cycle", {31'b0, in_setup}, 32'd0);
                in_setup = 1; lat_addr = paddr; lat_w = pwrite; lat_d = pwdata;
                hole = paddr[5:2] == 4'd1; wait_st = $urandom_range(0, 3);
                pready = $urandom_range(0, 1); prdata = $urandom;
            end else if (psel && penable) begin
                in_setup = 0;
                chk("paddr_stable", paddr, lat_addr);
                chk("pwrite_stable", {31'b0, pwrite}, {31'b0, lat_w});
                if (lat_w) chk("pwdata_stable", pwdata, lat_d);
                pready = !hole && acc_cnt == wait_st;
                prdata = pready ? smem[paddr[5:2]] : $urandom;
                acc_cnt++;
            end else begin
                if (in_setup) chk("setup_to_access", {31'b0, penable}, 32'd1);
                in_setup = 0;
                pready = $urandom_range(0, 1); prdata = $urandom;
            end
            prev_acc = psel && penable;
        end
    end
    always @(posedge pclk)
        if (!rst && psel && penable && pready && pwrite) smem[paddr[5:2]] <= pwdata;
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 500) begin @(negedge pclk); n++; end
        if (!cmd_ready) begin
            chk("push_ready", {31'b0, cmd_ready}, 32'd1);
            cmd_valid = 0;
            return;
        end
        @(posedge pclk);
        if (a[5:2] == 4'd1) exp_q.push_back({1'b1, 32'h0});
        else if (w) begin mmem[a[5:2]] = d; exp_q.push_back({1'b0, 32'h0}); end
        else exp_q.push_back({1'b0, mmem[a[5:2]]});
        @(negedge pclk);
        cmd_valid = 0;
    endtask
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge pclk); n++; end
        chk("drain", exp_q.size(), 32'd0);
        repeat (2) @(negedge pclk);
    endtask
    task automatic wait_psel(input logic en);
        int n = 0;
        while (!(psel && penable == en) && n < 200) begin @(negedge pclk); n++; end
        chk("wait_psel", {31'b0, psel}, 32'd1);
    endtask
    function automatic logic [31:0] raddr();
        logic [3:0] i = 4'($urandom_range(0, 15));
        if (i == 4'd1 && $urandom_range(0, 3) != 0) i = 4'd2;
        return {26'b0, i, 2'b00};
    endfunction
    initial begin
        n_chk = 0; n_fail = 0; mon_on = 0;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        pready = 0; prdata = '0;
        for (int i = 0; i < 16; i++) begin smem[i] = '0; mmem[i] = '0; end
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        rst = 0; mon_on = 1;
        @(negedge pclk);
        push(1, 32'h0, 32'hDEADBEEF); drain();
        push(0, 32'h0, 32'h0); drain();
        push(0, 32'h4, 32'h0); drain();
        push(0, 32'h4, 32'h0);
        wait_psel(1'b1);
        for (int i = 0; i < 4; i++) push(1'($urandom_range(0, 1)), {26'b0, 4'(i + 4), 2'b00}, $urandom);
        chk("full_ready", {31'b0, cmd_ready}, 32'd0);
        push(0, 32'h10, 32'h0);
        drain();
        push(0, 32'h4, 32'h0);
        wait_psel(1'b1);
        mon_on = 0; rst = 1; exp_q.delete();
        @(posedge pclk);
        @(negedge pclk);
        chk("midrst_psel", {31'b0, psel}, 32'd0);
        chk("midrst_penable", {31'b0, penable}, 32'd0);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        rst = 0;
        repeat (3) begin
            @(negedge pclk);
            chk("midrst_idle", {30'b0, psel, rsp_valid}, 32'd0);
        end
        mon_on = 1;
        push(1, 32'h8, 32'hA5A5_0123); push(0, 32'h8, 32'h0); drain();
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            push(1'($urandom_range(0, 1)), raddr(), $urandom);
        end
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
